// File: rtl/reg_dep_scoreboard.sv
// reg_dep_scoreboard: tracks in-flight destination registers and flags RAW hazards for the ID stage
module reg_dep_scoreboard #(
  parameter int REG_W     = 4,
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_src1,
  input  logic                         id_src1_used,
  input  logic [REG_W-1:0]             id_src2,
  input  logic                         id_src2_used,
  input  logic [REG_W-1:0]             id_dst,
  input  logic                         id_wr,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         dataDep,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NCMP = DEPTH - WB_BYPASS;
  logic [DEPTH-1:0] v;
  logic [REG_W-1:0] dst [DEPTH];
  logic             load, hit1, hit2, use1, use2;
  logic [CW-1:0]    cnt;
  assign load = id_valid && id_wr && !stall && !flush && !(ZERO_REG != 0 && id_dst == '0);
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) dst[i] <= '0;
    end else begin
      v[0]   <= load;
      dst[0] <= id_dst;
      for (int i = 1; i < DEPTH; i++) begin
        v[i]   <= v[i-1];
        dst[i] <= dst[i-1];
      end
    end
  // only registered state and decode fields feed the hit logic, keeping it off the stall loop
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    cnt  = '0;
    for (int i = 0; i < NCMP; i++) begin
      hit1 = hit1 | (v[i] && dst[i] == id_src1);
      hit2 = hit2 | (v[i] && dst[i] == id_src2);
    end
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v[i]);
  end
  assign use1     = id_src1_used && !(ZERO_REG != 0 && id_src1 == '0);
  assign use2     = id_src2_used && !(ZERO_REG != 0 && id_src2 == '0);
  assign dataDep  = id_valid && ((use1 && hit1) || (use2 && hit2));
  assign pend_cnt = cnt;
endmodule

// File: tb/tb_reg_dep_scoreboard.sv
// tb_reg_dep_scoreboard: directed vectors plus randomized timestamp-model checks, WB_BYPASS 1 and 0
module tb_reg_dep_scoreboard;
  localparam int DEPTH = 3;
  localparam int MAXE  = 4096;
  logic       clk = 1'b0;
  logic       rst, v, s1u, s2u, wr, st, fl, tie;
  logic [3:0] s1, s2, d;
  logic       dep_a, dep_b, stall_a, stall_b;
  logic [1:0] cnt_a, cnt_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign stall_a = st | (tie & dep_a);
  assign stall_b = st | (tie & dep_b);
  reg_dep_scoreboard u_a (
    .clk(clk), .rst(rst), .id_valid(v), .id_src1(s1), .id_src1_used(s1u),
    .id_src2(s2), .id_src2_used(s2u), .id_dst(d), .id_wr(wr),
    .stall(stall_a), .flush(fl), .dataDep(dep_a), .pend_cnt(cnt_a));
  reg_dep_scoreboard #(.WB_BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .id_valid(v), .id_src1(s1), .id_src1_used(s1u),
    .id_src2(s2), .id_src2_used(s2u), .id_dst(d), .id_wr(wr),
    .stall(stall_b), .flush(fl), .dataDep(dep_b), .pend_cnt(cnt_b));
  typedef struct {
    bit r, v; bit [3:0] s1; bit u1; bit [3:0] s2; bit u2; bit [3:0] d;
    bit w, st, fl, t; int ed, ec, ed0, ec0;
  } vec_t;
  vec_t tbl[$];
  // reference: acc[c][e] = dst accepted at edge e (-1 none); an accept at edge e sits k=n-e stages deep
  int acc [2][MAXE];
  int rste [2];
  int n = 0;
  bit mchk = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask
  function automatic bit hit(input int c, input int byp, input logic [3:0] s);
    for (int k = 0; k <= DEPTH - 1 - byp; k++)
      if (n - k >= 0 && n - k > rste[c] && acc[c][n-k] == int'(s)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit mdep(input int c, input int byp);
    return v && ((s1u && s1 != 0 && hit(c, byp, s1)) || (s2u && s2 != 0 && hit(c, byp, s2)));
  endfunction
  function automatic int mcnt(input int c);
    int r = 0;
    for (int k = 0; k < DEPTH; k++)
      if (n - k >= 0 && n - k > rste[c] && acc[c][n-k] >= 0) r++;
    return r;
  endfunction
  task automatic cyc();
    bit sa, sb;
    if (mchk) begin
      chk("model_dep_a", 32'(dep_a), 32'(mdep(0, 1)));
      chk("model_cnt_a", 32'(cnt_a), 32'(mcnt(0)));
      chk("model_dep_b", 32'(dep_b), 32'(mdep(1, 0)));
      chk("model_cnt_b", 32'(cnt_b), 32'(mcnt(1)));
    end
    sa = st | (tie & mdep(0, 1));
    sb = st | (tie & mdep(1, 0));
    @(posedge clk);
    n++;
    if (rst) begin
      acc[0][n] = -1; acc[1][n] = -1; rste[0] = n; rste[1] = n; mchk = 1'b1;
    end else begin
      acc[0][n] = (v && wr && !sa && !fl && d != 0) ? int'(d) : -1;
      acc[1][n] = (v && wr && !sb && !fl && d != 0) ? int'(d) : -1;
    end
    #1;
  endtask
  function automatic void add(input bit r, vv, input bit [3:0] a1, input bit u1, input bit [3:0] a2,
                              input bit u2, input bit [3:0] dd, input bit w, sst, ffl, t,
                              input int ed, ec, ed0, ec0);
    vec_t x;
    x.r = r; x.v = vv; x.s1 = a1; x.u1 = u1; x.s2 = a2; x.u2 = u2; x.d = dd;
    x.w = w; x.st = sst; x.fl = ffl; x.t = t; x.ed = ed; x.ec = ec; x.ed0 = ed0; x.ec0 = ec0;
    tbl.push_back(x);
  endfunction
  initial begin
    for (int c = 0; c < 2; c++) begin
      rste[c] = -1;
      for (int e = 0; e < MAXE; e++) acc[c][e] = -1;
    end
    // r v s1 u1 s2 u2 d w st fl t | depA cntA depB cntB (cnt -1 = unchecked)
    add(1,1,0,0,0,0,5,1,0,0,0, 0,-1,0,-1);
    add(1,1,0,0,0,0,5,1,0,0,0, 0,0,0,0);
    add(0,1,5,1,0,0,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,3,1,0,0,1, 0,0,0,0);
    add(0,1,3,1,0,0,0,0,0,0,1, 1,1,1,1);
    add(0,1,3,1,0,0,0,0,0,0,1, 1,1,1,1);
    add(0,1,3,1,0,0,0,0,0,0,1, 0,1,1,1);
    add(0,1,3,1,0,0,0,0,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,7,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,0,1, 0,1,0,1);
    add(0,1,0,0,7,1,0,0,0,0,1, 1,1,1,1);
    add(0,1,0,0,7,1,0,0,0,0,1, 0,1,1,1);
    add(0,1,0,0,7,1,0,0,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,7,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,0,1, 0,1,0,1);
    add(0,1,0,0,0,0,0,0,0,0,1, 0,1,0,1);
    add(0,1,0,0,7,1,0,0,0,0,1, 0,1,1,1);
    add(0,1,0,0,7,1,0,0,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,0,1,0,0,1, 0,0,0,0);
    add(0,1,0,1,0,0,0,0,0,0,1, 0,0,0,0);
    add(0,1,0,0,4,0,4,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,4,0,0,0,0,0,1, 0,1,0,1);
    add(0,0,0,0,0,0,0,0,0,0,1, 0,1,0,1);
    add(0,0,0,0,0,0,0,0,0,0,1, 0,1,0,1);
    add(0,1,0,0,0,0,9,1,0,1,0, 0,0,0,0);
    add(0,1,9,1,0,0,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,9,1,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,9,1,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,9,1,0,0,0, 0,0,0,0);
    add(0,1,9,1,0,0,0,0,0,0,0, 1,1,1,1);
    add(0,0,9,1,0,0,0,0,0,0,0, 0,1,0,1);
    add(0,0,9,1,0,0,0,0,0,0,0, 0,1,0,1);
    add(0,0,9,1,0,0,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,2,1,0,0,0, 0,0,0,0);
    add(1,1,2,1,0,0,0,0,0,0,0, 1,1,1,1);
    add(0,1,2,1,0,0,0,0,0,0,0, 0,0,0,0);
    foreach (tbl[i]) begin
      rst = tbl[i].r; v = tbl[i].v; s1 = tbl[i].s1; s1u = tbl[i].u1; s2 = tbl[i].s2;
      s2u = tbl[i].u2; d = tbl[i].d; wr = tbl[i].w; st = tbl[i].st; fl = tbl[i].fl; tie = tbl[i].t;
      #2;
      if (tbl[i].ec >= 0) begin
        chk($sformatf("vec%0d_dep_a", i), 32'(dep_a), 32'(tbl[i].ed));
        chk($sformatf("vec%0d_cnt_a", i), 32'(cnt_a), 32'(tbl[i].ec));
        chk($sformatf("vec%0d_dep_b", i), 32'(dep_b), 32'(tbl[i].ed0));
        chk($sformatf("vec%0d_cnt_b", i), 32'(cnt_b), 32'(tbl[i].ec0));
      end
      cyc();
    end
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) tie = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 4) != 0);
      s1  = 4'($urandom_range(0, 3));
      s2  = 4'($urandom_range(0, 3));
      d   = 4'($urandom_range(0, 3));
      s1u = 1'($urandom_range(0, 1));
      s2u = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      #2;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_dep_scoreboard.md
Name: reg_dep_scoreboard

Overview:
- Produces the `dataDep` signal that the pipeline's stall logic ORs into the global `stall`.
- Tracks destination registers of in-flight instructions (EX, MEM, WB) in a shift pipeline. Compares them against the source registers of the instruction currently in ID.
- The core has no forwarding, so any read-after-write hit on a pending destination holds ID until the write is visible in the register file.
- Sits beside the ID stage: consumes decode fields and the fed-back global `stall`, drives the stall unit.

Parameters:
- REG_W, 4, width of a register specifier (16 architectural registers).
- DEPTH, 3, number of tracked in-flight stages after ID (EX, MEM, WB).
- WB_BYPASS, 1, 1 = register file writes before reads, so the oldest entry (WB) is excluded from comparison; 0 = all DEPTH entries compared.
- ZERO_REG, 1, 1 = register 0 is hardwired zero: never tracked, never matched.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_src1  in  REG_W  first source register
- id_src1_used  in  1  instruction reads id_src1
- id_src2  in  REG_W  second source register
- id_src2_used  in  1  instruction reads id_src2
- id_dst  in  REG_W  destination register
- id_wr  in  1  instruction writes id_dst
- stall  in  1  global stall (fed back from stall unit; includes dataDep)
- flush  in  1  squash ID instruction (taken branch/redirect)
- dataDep  out  1  RAW dependency on a pending write; combinational
- pend_cnt  out  $clog2(DEPTH+1)  number of valid tracked entries (debug/perf)

Behaviour:
- State: DEPTH entries {v, dst}. Entry 0 = youngest (EX), entry DEPTH-1 = oldest (WB).
- Reset (rst high at a rising edge): all v cleared, dst cleared to 0. `pend_cnt` = 0 after reset.
- Reset mid-operation discards all pending entries. `dataDep` is 0 the cycle after reset regardless of ID inputs.
- Every non-reset edge the pipeline shifts unconditionally: entry[i] <= entry[i-1] for i >= 1. Downstream stages advance even while ID is stalled.
- entry[0] load:
  - Loads {1, id_dst} iff id_valid && id_wr && !stall && !flush && !(ZERO_REG && id_dst==0).
  - Otherwise entry[0] loads a bubble (v=0).
  - A stalled ID therefore inserts exactly one bubble per stall cycle.
- Entries already in flight are never cleared by flush or stall.
- Match rule:
  - matchN = srcN_used && !(ZERO_REG && srcN==0) && there exists i in [0, DEPTH-1-WB_BYPASS] with entry[i].v && entry[i].dst==srcN.
  - dataDep = id_valid && (match1 || match2).
- dataDep must not depend combinationally on `stall` or `flush`, to avoid a loop through the stall unit.
- An instruction never matches its own destination: it is not tracked until it leaves ID.
- Timing with DEPTH=3, WB_BYPASS=1:
  - Writer leaves ID at edge t.
  - It is in entry0 during cycle t+1, entry1 during t+2, entry2 during t+3.
  - A dependent consumer in ID at t+1 sees dataDep=1 during t+1 and t+2, and 0 during t+3.
  - Result: 2 stall cycles, 2 bubbles inserted.
  - With WB_BYPASS=0 the consumer stalls 3 cycles.
- Multiple matches (both sources, or several entries with the same dst) give the same single-bit dataDep. The youngest matching entry determines when it clears.
- id_valid=0 forces dataDep=0; the shift still occurs.
- Stall from a non-dependency source (e.g. return-sequence stall) still inserts bubbles; tracked entries drain normally.
- `pend_cnt` is the registered-state popcount of v, range 0..DEPTH.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1, id_wr=1, id_dst=5 -> after release pend_cnt=0, dataDep=0. Then src1=5 used with no prior writer -> dataDep=0.
- Back-to-back RAW (defaults): cycle0 writer dst=3 (stall=0); cycle1 consumer src1=3, stall tied to dataDep -> dataDep=1 in cycles 1,2 and 0 in cycle 3; pend_cnt sequence 1,1,1,0 (bubbles are not counted). Repeat with WB_BYPASS=0 -> 3 stall cycles.
- Distance 2: writer dst=7, one independent instruction, then consumer src2=7 -> dataDep=1 for exactly 1 cycle. Distance 3 -> dataDep never asserts.
- Zero register: writer dst=0 then consumer src1=0 -> dataDep=0, pend_cnt stays 0. Writer dst=4 with src2_used=0 and src2=4 -> dataDep=0.
- Flush/stall insertion: writer dst=9 presented with flush=1 -> not tracked, later src1=9 gives dataDep=0. Writer dst=9 held with external stall=1 for 2 cycles, then stall=0 -> tracked only once, from the edge where stall=0.
- Reset mid-operation: writer dst=2 tracked, rst asserted at the next edge with consumer src1=2 in ID -> dataDep=0 the cycle after reset, pend_cnt=0.
